// File: rtl/clk_en_monitor_if.sv
// Signal bundle between a clock-enable source and clk_en_monitor: the monitored
// pulse plus the measured-period and health-status outputs.
interface clk_en_monitor_if #(
    parameter int PW            = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     clk_en_in;
    logic [PW-1:0]            period;
    logic                     period_valid;
    logic                     locked;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic                     timeout;

    modport master (
        output clk_en_in,
        input  period,
        input  period_valid,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  timeout
    );

    modport slave (
        input  clk_en_in,
        output period,
        output period_valid,
        output locked,
        output err_pulse,
        output err_count,
        output timeout
    );
endinterface

// File: rtl/clk_en_monitor.sv
// Measures the interval between clock-enable pulses, declares lock after a run of
// in-tolerance periods, and flags/counts bad or missing pulses.
module clk_en_monitor #(
    parameter int INPUT_CLK_FREQ = 12500000,
    parameter int EXPECTED_FREQ  = 49716,
    parameter int TOLERANCE      = 1,
    parameter int LOCK_COUNT     = 4,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    clk_en_monitor_if.slave mon
);
    localparam int EXP = INPUT_CLK_FREQ / EXPECTED_FREQ;
    localparam int LO  = EXP - TOLERANCE;
    localparam int HI  = EXP + TOLERANCE;
    localparam int PW  = $clog2(HI + 2);
    localparam int GW  = $clog2(LOCK_COUNT + 1);

    localparam logic [PW-1:0]            LO_P   = PW'(LO);
    localparam logic [PW-1:0]            HI_P   = PW'(HI);
    localparam logic [PW-1:0]            ONE_P  = PW'(1);
    localparam logic [GW-1:0]            LOCK_G = GW'(LOCK_COUNT);
    localparam logic [GW-1:0]            ONE_G  = GW'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ONE_E  = ERR_CNT_WIDTH'(1);

    // IDLE: no pulse seen yet | ACQUIRE: counting good periods | LOCKED: stream in tolerance
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            cnt_q, cnt_d;
    logic [GW-1:0]            good_run_q, good_run_d;
    logic [PW-1:0]            period_q, period_d;
    logic                     period_valid_q, period_valid_d;
    logic                     locked_q, locked_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     timeout_q, timeout_d;

    logic [PW-1:0]            meas;
    logic                     in_range;
    logic [ERR_CNT_WIDTH-1:0] err_inc;

    // cnt never exceeds HI, so meas tops out at HI+1 and still fits in PW bits
    assign meas     = cnt_q + ONE_P;
    assign in_range = (meas >= LO_P) && (meas <= HI_P);
    assign err_inc  = (err_count_q != '1) ? (err_count_q + ONE_E) : err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            good_run_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_count_q    <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_run_q     <= good_run_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_pulse_q    <= err_pulse_d;
            err_count_q    <= err_count_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_run_d     = good_run_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_pulse_d    = 1'b0;
        err_count_d    = err_count_q;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                good_run_d = '0;
                if (mon.clk_en_in) begin
                    state_d = ACQUIRE;
                end
            end

            ACQUIRE, LOCKED: begin
                if (mon.clk_en_in) begin
                    cnt_d          = '0;
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    if (!in_range) begin
                        good_run_d = '0;
                        state_d    = ACQUIRE;
                        if (state_q == LOCKED) begin
                            err_pulse_d = 1'b1;
                            err_count_d = err_inc;
                        end
                    end else if (state_q == ACQUIRE) begin
                        good_run_d = good_run_q + ONE_G;
                        if ((good_run_q + ONE_G) == LOCK_G) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (cnt_q == HI_P) begin
                    // a pulse on this same cycle would have been a measurement instead
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                    good_run_d = '0;
                    if (state_q == LOCKED) begin
                        err_pulse_d = 1'b1;
                        err_count_d = err_inc;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_P;
                end
            end

            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                good_run_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    assign mon.period       = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.err_pulse    = err_pulse_q;
    assign mon.err_count    = err_count_q;
    assign mon.timeout      = timeout_q;
endmodule

// File: tb/tb_clk_en_monitor.sv
// Scoreboard bench for clk_en_monitor: expected strobe events are queued as pulses
// are driven and matched against the strobes the DUT actually produces.
module tb_clk_en_monitor;
    localparam int EXP = 251;
    localparam int HI  = 252;
    localparam int PW  = 8;
    localparam int EW  = 8;

    typedef struct packed {
        logic          pv;
        logic [PW-1:0] period;
        logic          locked;
        logic          err;
        logic [EW-1:0] ec;
        logic          to;
        logic [31:0]   cyc;
    } ev_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        clk_en = 1'b0;
    logic [31:0] cyc    = 32'd0;

    int            checks   = 0;
    int            failures = 0;
    int            low_run  = 0;
    logic [EW-1:0] exp_ec   = '0;
    logic [PW-1:0] last_period = '0;
    logic [31:0]   last_p   = 32'd0;
    ev_t           exp_q[$];
    ev_t           obs_q[$];
    ev_t           mon_ev;
    ev_t           e, o;

    clk_en_monitor_if #(.PW(PW), .ERR_CNT_WIDTH(EW)) mon ();
    clk_en_monitor_if #(.PW(PW), .ERR_CNT_WIDTH(2))  mon2 ();

    assign mon.clk_en_in  = clk_en;
    assign mon2.clk_en_in = clk_en;

    clk_en_monitor dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    clk_en_monitor #(.ERR_CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .mon   (mon2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(posedge clk) begin
        #1;
        if (mon.period_valid || mon.err_pulse || mon.timeout) begin
            mon_ev.pv     = mon.period_valid;
            mon_ev.period = mon.period;
            mon_ev.locked = mon.locked;
            mon_ev.err    = mon.err_pulse;
            mon_ev.ec     = mon.err_count;
            mon_ev.to     = mon.timeout;
            mon_ev.cyc    = cyc;
            obs_q.push_back(mon_ev);
        end
    end

    function automatic string fmt(input ev_t x);
        return $sformatf("cyc=%0d pv=%0b period=%0d locked=%0b err=%0b ec=%0d to=%0b",
                         x.cyc, x.pv, x.period, x.locked, x.err, x.ec, x.to);
    endfunction

    task automatic wait_low(input int n);
        repeat (n) begin
            @(negedge clk);
            clk_en = 1'b0;
        end
        low_run += n;
    endtask

    // gap 0: pulse on the next cycle regardless of spacing (entry from IDLE)
    task automatic pulse(input int gap, input bit ev, input bit lk, input bit er);
        ev_t x;
        if (gap > 0) begin
            repeat (gap - 1 - low_run) begin
                @(negedge clk);
                clk_en = 1'b0;
            end
        end
        @(negedge clk);
        clk_en  = 1'b1;
        low_run = 0;
        last_p  = cyc + 32'd1;
        if (er && exp_ec != '1) exp_ec = exp_ec + 8'd1;
        if (ev) begin
            last_period = PW'(gap);
            x.pv     = 1'b1;
            x.period = last_period;
            x.locked = lk;
            x.err    = er;
            x.ec     = exp_ec;
            x.to     = 1'b0;
            x.cyc    = last_p;
            exp_q.push_back(x);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        low_run = 0;
        exp_ec  = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mon.period !== '0)       begin failures++; $display("FAIL reset_period: got %0d want 0", mon.period); end
        checks++; if (mon.period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv: got %0b want 0", mon.period_valid); end
        checks++; if (mon.locked !== 1'b0)     begin failures++; $display("FAIL reset_locked: got %0b want 0", mon.locked); end
        checks++; if (mon.err_pulse !== 1'b0)  begin failures++; $display("FAIL reset_err: got %0b want 0", mon.err_pulse); end
        checks++; if (mon.err_count !== '0)    begin failures++; $display("FAIL reset_ec: got %0d want 0", mon.err_count); end
        checks++; if (mon.timeout !== 1'b0)    begin failures++; $display("FAIL reset_to: got %0b want 0", mon.timeout); end
        checks++; if (mon2.err_count !== 2'd0) begin failures++; $display("FAIL reset_ec_sat: got %0d want 0", mon2.err_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lock();
        pulse(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
        pulse(EXP, 1'b1, 1'b1, 1'b0);
        pulse(EXP, 1'b1, 1'b1, 1'b0);
        wait_low(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL lock_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL lock_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL lock_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
        checks++;
        if (mon.err_count !== '0) begin failures++; $display("FAIL lock_ec: got %0d want 0", mon.err_count); end
    endtask

    task automatic test_tolerance();
        pulse(EXP - 1, 1'b1, 1'b1, 1'b0);
        pulse(EXP + 1, 1'b1, 1'b1, 1'b0);
        pulse(EXP + 2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pulse((i % 2 == 0) ? EXP + 1 : EXP - 1, 1'b1, (i == 3), 1'b0);
        pulse(EXP - 2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
        wait_low(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL tol_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL tol_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL tol_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
    endtask

    task automatic test_timeout();
        ev_t x;
        pulse(EXP, 1'b1, 1'b1, 1'b0);
        exp_ec   = exp_ec + 8'd1;
        x.pv     = 1'b0;
        x.period = last_period;
        x.locked = 1'b0;
        x.err    = 1'b1;
        x.ec     = exp_ec;
        x.to     = 1'b1;
        x.cyc    = last_p + HI + 1;
        exp_q.push_back(x);
        wait_low(260);
        pulse(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
        wait_low(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL timeout_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL timeout_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL timeout_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(EXP, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
        wait_low(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL b2b_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL b2b_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
    endtask

    task automatic test_err_saturation();
        logic [1:0] want_sat;
        do_reset();
        pulse(0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
            pulse(EXP + 2, 1'b1, 1'b0, 1'b1);
            wait_low(1);
            want_sat = (k >= 2) ? 2'd3 : 2'(k + 1);
            checks++;
            if (mon2.err_count !== want_sat) begin
                failures++; $display("FAIL sat_ec round %0d: got %0d want %0d", k, mon2.err_count, want_sat);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL sat_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL sat_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL sat_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
    endtask

    task automatic test_reset_while_locked();
        do_reset();
        pulse(0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) pulse(EXP, 1'b1, (i == 3), 1'b0);
            if (k < 2) pulse(EXP - 2, 1'b1, 1'b0, 1'b1);
        end
        wait_low(100);
        checks++;
        if (mon.err_count !== 8'd2 || mon.locked !== 1'b1) begin
            failures++; $display("FAIL rwl_pre: got ec=%0d locked=%0b want ec=2 locked=1", mon.err_count, mon.locked);
        end
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mon.period !== '0)         begin failures++; $display("FAIL rwl_period: got %0d want 0", mon.period); end
        checks++; if (mon.period_valid !== 1'b0) begin failures++; $display("FAIL rwl_pv: got %0b want 0", mon.period_valid); end
        checks++; if (mon.locked !== 1'b0)       begin failures++; $display("FAIL rwl_locked: got %0b want 0", mon.locked); end
        checks++; if (mon.err_pulse !== 1'b0)    begin failures++; $display("FAIL rwl_err: got %0b want 0", mon.err_pulse); end
        checks++; if (mon.err_count !== '0)      begin failures++; $display("FAIL rwl_ec: got %0d want 0", mon.err_count); end
        checks++; if (mon.timeout !== 1'b0)      begin failures++; $display("FAIL rwl_to: got %0b want 0", mon.timeout); end
        @(negedge clk);
        reset   = 1'b0;
        low_run = 0;
        exp_ec  = '0;
        pulse(0, 1'b0, 1'b0, 1'b0);
        pulse(EXP, 1'b1, 1'b0, 1'b0);
        wait_low(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL rwl_event: got none, want %s", fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rwl_event: got %s, want %s", fmt(o), fmt(e)); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rwl_extra: got %0d extra events (first %s), want 0", obs_q.size(), fmt(obs_q[0])); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_timeout();
        test_back_to_back();
        test_err_saturation();
        test_reset_while_locked();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
